// File: rtl/cpu_pkg.sv
// Shared types and sizes for the datapath: ALU operations, register-file
// write sources, widths and memory depths.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int RF_DEPTH = 16;
  localparam int DM_DEPTH = 256;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_ZERO = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_CONS = 2'b10,
    SRC_ZERO = 2'b11
  } rf_src_t;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] c);
    return {{(DATA_W-8){c[7]}}, c};
  endfunction

endpackage

// File: rtl/regfile16x16.sv
// 16 x 16-bit register file: two gated combinational read ports, one debug
// read port and one synchronous write port cleared by synchronous reset.
module regfile16x16
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_wr,
  input  logic [3:0]        p_addr,
  input  logic              p_rd,
  input  logic [3:0]        q_addr,
  input  logic              q_rd,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] p_data,
  output logic [DATA_W-1:0] q_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [0:RF_DEPTH-1];

  // Register storage; reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (w_wr) begin
      regs[w_addr] <= w_data;
    end
  end

  // Reads see the pre-write value during a same-address write.
  assign p_data   = p_rd ? regs[p_addr] : 16'h0000;
  assign q_data   = q_rd ? regs[q_addr] : 16'h0000;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/datapath.sv
// Single-cycle datapath: register file, ALU, write-source mux and a
// 256-word data memory that is not touched by reset.
module datapath
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  D_addr,
  input  logic        D_rd,
  input  logic        D_wr,
  input  logic        RF_s0,
  input  logic        RF_s1,
  input  logic [3:0]  RF_W_addr,
  input  logic        RF_W_wr,
  input  logic [3:0]  RF_Rp_addr,
  input  logic [3:0]  RF_Rq_addr,
  input  logic        RF_Rp_rd,
  input  logic        RF_Rq_rd,
  input  logic [7:0]  RF_W_cons,
  input  logic        alu_s0,
  input  logic        alu_s1,
  output logic        RF_Rp_zero,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [DATA_W-1:0] rp_data;
  logic [DATA_W-1:0] rq_data;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] dmem [0:DM_DEPTH-1];
  alu_op_t           alu_op;
  rf_src_t           rf_src;

  assign alu_op = alu_op_t'({alu_s1, alu_s0});
  assign rf_src = rf_src_t'({RF_s1, RF_s0});

  regfile16x16 u_rf (
    .clk      (clk),
    .rst      (rst),
    .w_addr   (RF_W_addr),
    .w_data   (w_data),
    .w_wr     (RF_W_wr),
    .p_addr   (RF_Rp_addr),
    .p_rd     (RF_Rp_rd),
    .q_addr   (RF_Rq_addr),
    .q_rd     (RF_Rq_rd),
    .dbg_addr (dbg_addr),
    .p_data   (rp_data),
    .q_data   (rq_data),
    .dbg_data (dbg_data)
  );

  // ALU, modulo 2^16 with carry and borrow dropped.
  always_comb begin
    alu_res = 16'h0000;
    case (alu_op)
      ALU_PASS: alu_res = rp_data;
      ALU_ADD:  alu_res = rp_data + rq_data;
      ALU_SUB:  alu_res = rp_data - rq_data;
      ALU_ZERO: alu_res = 16'h0000;
      default:  alu_res = 16'h0000;
    endcase
  end

  // Register-file write source select.
  always_comb begin
    w_data = 16'h0000;
    case (rf_src)
      SRC_ALU:  w_data = alu_res;
      SRC_MEM:  w_data = mem_rd_data;
      SRC_CONS: w_data = sext8(RF_W_cons);
      SRC_ZERO: w_data = 16'h0000;
      default:  w_data = 16'h0000;
    endcase
  end

  // Data memory store of port-P data; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && D_wr) begin
      dmem[D_addr] <= rp_data;
    end
  end

  assign mem_rd_data = D_rd ? dmem[D_addr] : 16'h0000;
  assign RF_Rp_zero  = (rp_data == 16'h0000);

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a behavioural model checked every cycle,
// plus literal expectations at key points of the instruction sequence.
module tb_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  D_addr;
  logic        D_rd, D_wr;
  logic        RF_s0, RF_s1;
  logic [3:0]  RF_W_addr;
  logic        RF_W_wr;
  logic [3:0]  RF_Rp_addr, RF_Rq_addr;
  logic        RF_Rp_rd, RF_Rq_rd;
  logic [7:0]  RF_W_cons;
  logic        alu_s0, alu_s1;
  logic        RF_Rp_zero;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int tests = 0;
  int fails = 0;

  datapath dut (
    .clk(clk), .rst(rst), .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
    .RF_s0(RF_s0), .RF_s1(RF_s1), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
    .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
    .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd), .RF_W_cons(RF_W_cons),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .RF_Rp_zero(RF_Rp_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: register and memory contents plus known-value flags.
  logic [15:0] rf_m [0:15];
  bit          rf_known [0:15];
  logic [15:0] dm_m [0:255];
  bit          dm_known [0:255];

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf_m[i] = 16'h0000;
      rf_known[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      dm_m[i] = 16'h0000;
      dm_known[i] = 1'b0;
    end
  end

  // Model update at each rising edge from the inputs held during the cycle.
  always @(posedge clk) begin
    logic [15:0] p, q, a, m, w;
    bit          wk;
    int          sel;
    p = RF_Rp_rd ? rf_m[RF_Rp_addr] : 16'h0000;
    q = RF_Rq_rd ? rf_m[RF_Rq_addr] : 16'h0000;
    sel = {alu_s1, alu_s0};
    if (sel == 0) a = p;
    else if (sel == 1) a = p + q;
    else if (sel == 2) a = p - q;
    else a = 16'h0000;
    m = D_rd ? dm_m[D_addr] : 16'h0000;
    sel = {RF_s1, RF_s0};
    wk = 1'b1;
    if (sel == 0) begin
      w = a;
      wk = (!RF_Rp_rd || rf_known[RF_Rp_addr]) && (!RF_Rq_rd || rf_known[RF_Rq_addr]);
    end else if (sel == 1) begin
      w = m;
      wk = !D_rd || dm_known[D_addr];
    end else if (sel == 2) begin
      w = {{8{RF_W_cons[7]}}, RF_W_cons};
    end else begin
      w = 16'h0000;
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf_m[i] = 16'h0000;
        rf_known[i] = 1'b1;
      end
    end else begin
      if (D_wr) begin
        dm_m[D_addr] = p;
        dm_known[D_addr] = !RF_Rp_rd || rf_known[RF_Rp_addr];
      end
      if (RF_W_wr) begin
        rf_m[RF_W_addr] = w;
        rf_known[RF_W_addr] = wk;
      end
    end
  end

  // Compare process: combinational outputs against the model every cycle.
  always @(negedge clk) begin
    logic [15:0] p;
    if (rf_known[dbg_addr]) begin
      tests++;
      if (dbg_data !== rf_m[dbg_addr]) begin
        fails++;
        $display("FAIL model_dbg t=%0t addr=%0d got=%h exp=%h", $time, dbg_addr, dbg_data, rf_m[dbg_addr]);
      end
    end
    if (!RF_Rp_rd || rf_known[RF_Rp_addr]) begin
      p = RF_Rp_rd ? rf_m[RF_Rp_addr] : 16'h0000;
      tests++;
      if (RF_Rp_zero !== (p == 16'h0000)) begin
        fails++;
        $display("FAIL model_zero t=%0t got=%b exp=%b", $time, RF_Rp_zero, (p == 16'h0000));
      end
    end
  end

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; D_addr = 8'h00; D_rd = 1'b0; D_wr = 1'b0;
    RF_s0 = 1'b0; RF_s1 = 1'b0; RF_W_addr = 4'h0; RF_W_wr = 1'b0;
    RF_Rp_addr = 4'h0; RF_Rq_addr = 4'h0; RF_Rp_rd = 1'b0; RF_Rq_rd = 1'b0;
    RF_W_cons = 8'h00; alu_s0 = 1'b0; alu_s1 = 1'b0; dbg_addr = 4'h0;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic wr_cons(input logic [3:0] dst, input logic [7:0] c);
    next();
    RF_s1 = 1'b1; RF_W_wr = 1'b1; RF_W_addr = dst; RF_W_cons = c;
  endtask

  task automatic alu(input logic [3:0] dst, input logic [3:0] p, input logic [3:0] q, input logic [1:0] op);
    next();
    RF_Rp_rd = 1'b1; RF_Rp_addr = p; RF_Rq_rd = 1'b1; RF_Rq_addr = q;
    alu_s1 = op[1]; alu_s0 = op[0]; RF_W_wr = 1'b1; RF_W_addr = dst;
  endtask

  task automatic store(input logic [3:0] p, input logic [7:0] a);
    next();
    RF_Rp_rd = 1'b1; RF_Rp_addr = p; D_wr = 1'b1; D_addr = a;
  endtask

  task automatic load(input logic [3:0] dst, input logic [7:0] a);
    next();
    D_rd = 1'b1; D_addr = a; RF_s0 = 1'b1; RF_W_wr = 1'b1; RF_W_addr = dst;
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [15:0] exp);
    next();
    dbg_addr = a;
    #1;
    check16(name, dbg_data, exp);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    idle();

    // Reset state: every register zero, port P disabled reads as zero.
    for (int i = 0; i < 16; i++) begin
      dbg_addr = i[3:0];
      #1;
      check16("reset_dbg", dbg_data, 16'h0000);
    end
    check16("reset_zero", {15'h0000, RF_Rp_zero}, 16'h0001);

    // Sign-extended constants, then an add that wraps to zero.
    wr_cons(4'd1, 8'h05);
    wr_cons(4'd2, 8'hFB);
    alu(4'd3, 4'd1, 4'd2, 2'b01);
    peek("r1_cons", 4'd1, 16'h0005);
    peek("r2_cons", 4'd2, 16'hFFFB);
    peek("r3_add", 4'd3, 16'h0000);
    next();
    RF_Rp_rd = 1'b1; RF_Rp_addr = 4'd3;
    #1;
    check16("r3_zero", {15'h0000, RF_Rp_zero}, 16'h0001);

    // Subtraction with borrow, then doubling with wrap.
    wr_cons(4'd1, 8'h03);
    wr_cons(4'd2, 8'h05);
    alu(4'd4, 4'd1, 4'd2, 2'b10);
    peek("r4_sub", 4'd4, 16'hFFFE);
    alu(4'd5, 4'd4, 4'd4, 2'b01);
    peek("r5_add", 4'd5, 16'hFFFC);
    alu(4'd6, 4'd4, 4'd2, 2'b00);
    peek("r6_pass", 4'd6, 16'hFFFE);
    alu(4'd6, 4'd4, 4'd2, 2'b11);
    peek("r6_zero_op", 4'd6, 16'h0000);

    // Store and load through the data memory.
    wr_cons(4'd1, 8'h05);
    store(4'd1, 8'hFF);
    load(4'd7, 8'hFF);
    peek("r7_load", 4'd7, 16'h0005);

    // Same-cycle read and write of one memory word returns the old word.
    wr_cons(4'd8, 8'h09);
    next();
    RF_Rp_rd = 1'b1; RF_Rp_addr = 4'd8; D_wr = 1'b1; D_rd = 1'b1; D_addr = 8'hFF;
    RF_s0 = 1'b1; RF_W_wr = 1'b1; RF_W_addr = 4'd10;
    peek("r10_rw_old", 4'd10, 16'h0005);
    load(4'd11, 8'hFF);
    peek("r11_rw_new", 4'd11, 16'h0009);
    store(4'd1, 8'hFF);

    // Write-then-read of R9: old value this cycle, new value next cycle.
    wr_cons(4'd9, 8'h12);
    wr_cons(4'd9, 8'h34);
    RF_Rp_rd = 1'b1; RF_Rp_addr = 4'd9; dbg_addr = 4'd9;
    #1;
    check16("r9_old", dbg_data, 16'h0012);
    check16("r9_old_zero", {15'h0000, RF_Rp_zero}, 16'h0000);
    peek("r9_new", 4'd9, 16'h0034);

    // Reset discards register and memory writes but keeps memory contents.
    next();
    rst = 1'b1;
    RF_s1 = 1'b1; RF_W_wr = 1'b1; RF_W_addr = 4'd5; RF_W_cons = 8'h77;
    RF_Rp_rd = 1'b1; RF_Rp_addr = 4'd9; D_wr = 1'b1; D_addr = 8'hFF;
    peek("r5_after_rst", 4'd5, 16'h0000);
    peek("r9_after_rst", 4'd9, 16'h0000);
    load(4'd12, 8'hFF);
    peek("dm_ff_kept", 4'd12, 16'h0005);

    next();
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising clock edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 D_addr  input  8  data-memory word address.
REQ-005 D_rd  input  1  data-memory read enable.
REQ-006 D_wr  input  1  data-memory write enable.
REQ-007 RF_s0, RF_s1  input  1 each  register-file write-source select {s1,s0}.
REQ-008 RF_W_addr  input  4  register-file write address.
REQ-009 RF_W_wr  input  1  register-file write enable.
REQ-010 RF_Rp_addr, RF_Rq_addr  input  4 each  read-port P/Q addresses.
REQ-011 RF_Rp_rd, RF_Rq_rd  input  1 each  read-port P/Q enables.
REQ-012 RF_W_cons  input  8  immediate constant.
REQ-013 alu_s0, alu_s1  input  1 each  ALU operation select {s1,s0}.
REQ-014 RF_Rp_zero  output  1  high when read-port P data equals 16'h0000.
REQ-015 dbg_addr  input  4  debug register-file read address.
REQ-016 dbg_data  output  16  debug read data, equal to RF[dbg_addr].

Function
REQ-017 Register file: 16 x 16-bit, two combinational read ports (P, Q), plus one combinational debug port and one synchronous write port.
REQ-018 Rp_data SHALL be RF[RF_Rp_addr] when RF_Rp_rd=1, else 16'h0000; Rq_data likewise with Q signals.
REQ-019 RF_Rp_zero SHALL be combinational (Rp_data==0), so it is 1 whenever RF_Rp_rd=0.
REQ-020 ALU on {alu_s1,alu_s0}: 00 pass Rp_data; 01 Rp_data+Rq_data; 10 Rp_data-Rq_data; 11 16'h0000; all arithmetic modulo 2^16, carry/borrow discarded.
REQ-021 Write-data mux on {RF_s1,RF_s0}: 00 ALU result; 01 data-memory read data; 10 RF_W_cons sign-extended to 16 bits; 11 16'h0000.
REQ-022 When RF_W_wr=1, RF[RF_W_addr] SHALL take the write data at the next rising edge; single-cycle latency.
REQ-023 Read during a write to the same address in the same cycle SHALL return the old value; new value is visible the following cycle.
REQ-024 Data memory: 256 x 16-bit, combinational read, synchronous write.
REQ-025 Memory read data SHALL be DM[D_addr] when D_rd=1, else 16'h0000.
REQ-026 When D_wr=1, DM[D_addr] SHALL take Rp_data at the next rising edge; with RF_Rp_rd=0 this stores 16'h0000.
REQ-027 D_rd and D_wr both high: write performed; read returns the pre-write value that cycle.
REQ-028 A load (D_rd=1, RF_s=01, RF_W_wr=1) SHALL complete in a single cycle.

Reset
REQ-029 While rst=1 at a rising edge, all 16 registers SHALL clear to 16'h0000 and RF_W_wr/D_wr SHALL be ignored.
REQ-030 Data-memory contents SHALL be unaffected by reset.
REQ-031 Reset asserted mid-sequence SHALL discard any write presented in that cycle.

Structure
REQ-032 Package cpu_pkg SHALL hold the ALU-op and RF-source enumerations, data width 16, RF depth 16, DM depth 256.
REQ-033 The register file SHALL be a sub-module regfile16x16; the ALU, write mux and data memory SHALL stay in datapath.

Verification
REQ-034 Reset, then dbg_addr sweeping 0..15 -> dbg_data=0 at every address; RF_Rp_rd=0 -> RF_Rp_zero=1.
REQ-035 Load constant 8'h05 to R1 and 8'hFB to R2 (RF_s=10) -> R1=16'h0005, R2=16'hFFFB; then ADD R3=R1+R2 -> R3=16'h0000 and Rp_zero=1 when reading R3.
REQ-036 R1=3, R2=5, SUB R4=R1-R2 -> R4=16'hFFFE; R4+R4 -> 16'hFFFC, with wrap-around.
REQ-037 Store R1 (16'h0005) to D_addr 8'hFF, then load 8'hFF into R7 -> R7=16'h0005; same-cycle D_rd+D_wr at 8'hFF returns the old value.
REQ-038 Write R9 while reading R9 on port P -> old value that cycle, new value next cycle.
REQ-039 rst=1 in the same cycle as RF_W_wr=1 to R5 -> R5=0 afterwards; previously stored DM[8'hFF] is still 16'h0005.
